// File: rtl/fir_tap_window.sv
// fir_tap_window: streaming front end of the FIR datapath.
// It shifts accepted Q16.16 samples into a NUM_REGS-deep tap window and holds a
// writable coefficient bank. Both are presented to mac with a valid/ready handshake.
// Build option: define ZERO_FILL_EN to present zero-padded windows from the
// first accepted sample. When it is left undefined, windows are only presented
// once the window is full.
module fir_tap_window #(
    parameter int DATA_WIDTH = 32,
    parameter int Q_FORMAT   = 16,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [DATA_WIDTH-1:0]                sampleIn,
    input  logic                                 sampleValid,
    output logic                                 sampleReady,
    input  logic                                 coefWrEn,
    input  logic [ADDR_WIDTH-1:0]                coefAddr,
    input  logic [DATA_WIDTH-1:0]                coefData,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  pDataOut,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  coefsOut,
    output logic                                 tapsValid,
    input  logic                                 tapsReady,
    output logic [ADDR_WIDTH:0]                  fillCount
);

    // Q_FORMAT only documents the fixed-point interpretation; values pass bit-exact.
    if (Q_FORMAT < 0 || Q_FORMAT >= DATA_WIDTH) begin : g_bad_q_format
        $error("fir_tap_window: Q_FORMAT must lie in [0, DATA_WIDTH)");
    end

    // A window needs at least two taps for the shift concatenation below.
    if (NUM_REGS < 2) begin : g_bad_num_regs
        $error("fir_tap_window: NUM_REGS must be at least 2");
    end

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } state_t;

    localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH:0] FILL_ONE = (ADDR_WIDTH+1)'(1);

    state_t              state;
    state_t              state_next;
    logic [ADDR_WIDTH:0] fill_next;
    logic                accept;
    logic                window_eligible;

    // A frozen, unconsumed window blocks new samples; there is no skid buffer.
    assign sampleReady = !rst && !flush && (!tapsValid || tapsReady);
    assign accept      = sampleValid && sampleReady;

    // Fill level and window state that an accept in this cycle moves to.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        fill_next  = fillCount;
        state_next = state;
        if (state != FULL) begin
            fill_next = fillCount + FILL_ONE;
        end
        state_next = (fill_next == FILL_MAX) ? FULL : FILLING;
    end

`ifdef ZERO_FILL_EN
    // A zero-padded window is usable as soon as it holds one real sample.
    assign window_eligible = 1'b1;
`else
    // Only a completely filled window is handed to mac.
    assign window_eligible = (state_next == FULL);
`endif

    // Tap window, fill tracking and window handshake. Reset beats flush, and flush beats accept.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments, so every register sees pre-edge values.
        if (rst) begin
            pDataOut  <= '0;
            fillCount <= '0;
            tapsValid <= 1'b0;
            state     <= EMPTY;
        end else if (flush) begin
            pDataOut  <= '0;
            fillCount <= '0;
            tapsValid <= 1'b0;
            state     <= EMPTY;
        end else if (accept) begin
            pDataOut  <= {pDataOut[NUM_REGS-2:0], sampleIn};
            fillCount <= fill_next;
            state     <= state_next;
            tapsValid <= window_eligible;
        end else if (tapsReady) begin
            tapsValid <= 1'b0;
        end
    end

    // Coefficient bank: writes are legal in any cycle, and out-of-range indices are dropped.
    always_ff @(posedge clk) begin
        // NOTE: this small register bank is reset on purpose, because mac must see zero coefficients after reset.
        if (rst) begin
            coefsOut <= '0;
        end else if (coefWrEn && (int'(coefAddr) < NUM_REGS)) begin
            coefsOut[coefAddr] <= coefData;
        end
    end

endmodule

// File: tb/tb_fir_tap_window.sv
// tb_fir_tap_window: self-checking bench for fir_tap_window. It uses a vector table,
// hand sequences and a random phase, all compared against a queue-based window model.
module tb_fir_tap_window;

    localparam int DW = 32;
    localparam int N  = 8;
    localparam int AW = 3;
`ifdef ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst, flush, sampleValid, coefWrEn, tapsReady;
    logic [DW-1:0]         sampleIn, coefData;
    logic [AW-1:0]         coefAddr;
    logic                  sampleReady, tapsValid;
    logic [N-1:0][DW-1:0]  pDataOut, coefsOut;
    logic [AW:0]           fillCount;

    // The second instance has a non-power-of-two bank, so out-of-range addresses can be driven.
    logic                  c6_wr;
    logic [2:0]            c6_addr;
    logic [DW-1:0]         c6_data;
    logic [5:0][DW-1:0]    c6_taps, c6_coefs;
    logic                  c6_ready, c6_valid;
    logic [3:0]            c6_fill;

    always #5 clk = ~clk;

    fir_tap_window #(.DATA_WIDTH(DW), .Q_FORMAT(16), .NUM_REGS(N)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .sampleIn(sampleIn), .sampleValid(sampleValid), .sampleReady(sampleReady),
        .coefWrEn(coefWrEn), .coefAddr(coefAddr), .coefData(coefData),
        .pDataOut(pDataOut), .coefsOut(coefsOut),
        .tapsValid(tapsValid), .tapsReady(tapsReady), .fillCount(fillCount)
    );

    fir_tap_window #(.DATA_WIDTH(DW), .Q_FORMAT(16), .NUM_REGS(6)) u_dut6 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .sampleIn('0), .sampleValid(1'b0), .sampleReady(c6_ready),
        .coefWrEn(c6_wr), .coefAddr(c6_addr), .coefData(c6_data),
        .pDataOut(c6_taps), .coefsOut(c6_coefs),
        .tapsValid(c6_valid), .tapsReady(1'b0), .fillCount(c6_fill)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: index 0 of the queue is the newest sample.
    logic [DW-1:0] m_win[$];
    logic [DW-1:0] m_coef[N];
    int            m_fill;
    bit            m_valid;

    typedef struct {
        logic [DW-1:0] sample;
        logic          exp_tv;
        logic [AW:0]   exp_fill;
        logic [DW-1:0] exp_tap0;
        logic [DW-1:0] exp_tap_last;
    } vec_t;
    vec_t vecs[N];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] win_bits();
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = m_win[i];
        return r;
    endfunction

    function automatic logic [N*DW-1:0] coef_bits();
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = m_coef[i];
        return r;
    endfunction

    task automatic model_reset();
        m_win = {};
        for (int i = 0; i < N; i++) m_win.push_back('0);
        for (int i = 0; i < N; i++) m_coef[i] = '0;
        m_fill  = 0;
        m_valid = 1'b0;
    endtask

    // Called just after a negedge with the inputs already driven. It checks ready,
    // advances the model by one clock, and compares all registered outputs at the next negedge.
    task automatic step(input string tag);
        bit exp_ready, acc;
        #1;
        exp_ready = !rst && !flush && (!m_valid || tapsReady);
        check({tag, ".ready"}, 512'(sampleReady), 512'(exp_ready));
        acc = sampleValid && exp_ready;
        if (rst) begin
            model_reset();
        end else begin
            if (coefWrEn && int'(coefAddr) < N) m_coef[coefAddr] = coefData;
            if (flush) begin
                foreach (m_win[i]) m_win[i] = '0;
                m_fill  = 0;
                m_valid = 1'b0;
            end else if (acc) begin
                m_win.push_front(sampleIn);
                void'(m_win.pop_back());
                if (m_fill < N) m_fill++;
                m_valid = ZF || (m_fill == N);
            end else if (tapsReady) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        check({tag, ".taps"},  512'(pDataOut),  512'(win_bits()));
        check({tag, ".coefs"}, 512'(coefsOut),  512'(coef_bits()));
        check({tag, ".valid"}, 512'(tapsValid), 512'(m_valid));
        check({tag, ".fill"},  512'(fillCount), 512'(m_fill));
    endtask

    initial begin
        logic [5:0][DW-1:0] e6;
        logic [N-1:0][DW-1:0] all_coef;

        rst = 1'b1; flush = 1'b0; sampleValid = 1'b0; sampleIn = '0;
        coefWrEn = 1'b0; coefAddr = '0; coefData = '0; tapsReady = 1'b0;
        c6_wr = 1'b0; c6_addr = '0; c6_data = '0;
        model_reset();
        @(negedge clk);

        // Reset held for two cycles, then released.
        step("rst0");
        step("rst1");
        check("rst.taps_zero", 512'(pDataOut), '0);
        rst = 1'b0;
        step("idle");
        check("idle.ready_high", 512'(sampleReady), 512'(1'b1));

        // Table-driven fill with samples 1.0 .. 8.0 while downstream is always ready.
        for (int i = 0; i < N; i++) begin
            vecs[i].sample       = DW'(i + 1) << 16;
            vecs[i].exp_tv       = ZF || (i == N - 1);
            vecs[i].exp_fill     = (AW+1)'(i + 1);
            vecs[i].exp_tap0     = DW'(i + 1) << 16;
            vecs[i].exp_tap_last = (i == N - 1) ? 32'h0001_0000 : 32'h0;
        end
        for (int i = 0; i < N; i++) begin
            sampleValid = 1'b1; tapsReady = 1'b1; sampleIn = vecs[i].sample;
            step("fill");
            check("fill.tv",       512'(tapsValid),      512'(vecs[i].exp_tv));
            check("fill.count",    512'(fillCount),      512'(vecs[i].exp_fill));
            check("fill.tap0",     512'(pDataOut[0]),    512'(vecs[i].exp_tap0));
            check("fill.tap_last", 512'(pDataOut[N-1]),  512'(vecs[i].exp_tap_last));
        end

        // Backpressure: the window stays frozen while tapsReady is low.
        tapsReady = 1'b0; sampleValid = 1'b1; sampleIn = 32'h0009_0000;
        for (int i = 0; i < 5; i++) begin
            step("bp");
            check("bp.hold_tap0", 512'(pDataOut[0]), 512'(32'h0008_0000));
            check("bp.ready_low", 512'(sampleReady), 512'(1'b0));
        end
        tapsReady = 1'b1;
        step("bp_release");
        check("bp.new_tap0", 512'(pDataOut[0]), 512'(32'h0009_0000));

        // Streaming: one window per cycle with no gaps.
        for (int i = 0; i < 20; i++) begin
            sampleIn = $urandom();
            step("stream");
            check("stream.tv",   512'(tapsValid), 512'(1'b1));
            check("stream.fill", 512'(fillCount), 512'(N));
        end

        // Coefficient bank load with 0.2 in Q16.16.
        sampleValid = 1'b0;
        for (int a = 0; a < N; a++) begin
            coefWrEn = 1'b1; coefAddr = AW'(a); coefData = 32'h0000_3333;
            step("coef");
        end
        coefWrEn = 1'b0;
        for (int i = 0; i < N; i++) all_coef[i] = 32'h0000_3333;
        check("coef.all", 512'(coefsOut), 512'(all_coef));

        // Refill, then flush with a colliding sample: the sample is dropped and the coefficients are kept.
        sampleValid = 1'b1;
        for (int i = 0; i < N; i++) begin
            sampleIn = $urandom();
            step("refill");
        end
        flush = 1'b1; sampleIn = 32'hDEAD_BEEF;
        step("flush");
        flush = 1'b0; sampleValid = 1'b0;
        check("flush.taps",  512'(pDataOut),  '0);
        check("flush.fill",  512'(fillCount), '0);
        check("flush.tv",    512'(tapsValid), '0);
        check("flush.coefs", 512'(coefsOut),  512'(all_coef));

        // Reset in the middle of filling.
        sampleValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sampleIn = $urandom();
            step("partial");
        end
        check("partial.fill", 512'(fillCount), 512'(3));
        rst = 1'b1; sampleValid = 1'b0;
        step("midrst");
        rst = 1'b0;
        check("midrst.taps",  512'(pDataOut),  '0);
        check("midrst.coefs", 512'(coefsOut),  '0);
        check("midrst.tv",    512'(tapsValid), '0);
        check("midrst.fill",  512'(fillCount), '0);
        step("post_rst");

        // Random traffic with occasional flush, reset and coefficient writes.
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(99) < 2);
            flush       = ($urandom_range(99) < 5);
            sampleValid = ($urandom_range(99) < 70);
            tapsReady   = ($urandom_range(99) < 60);
            sampleIn    = $urandom();
            coefWrEn    = ($urandom_range(99) < 20);
            coefAddr    = AW'($urandom_range(N - 1));
            coefData    = $urandom();
            step("rand");
        end
        rst = 1'b0; flush = 1'b0; sampleValid = 1'b0; coefWrEn = 1'b0;

        // Six-entry bank: writes to addresses 6 and 7 must change nothing.
        for (int i = 0; i < 6; i++) e6[i] = 32'h0000_1000 + DW'(i);
        for (int a = 0; a < 8; a++) begin
            c6_wr = 1'b1; c6_addr = 3'(a); c6_data = 32'h0000_1000 + DW'(a);
            @(negedge clk);
        end
        c6_wr = 1'b0;
        @(negedge clk);
        check("c6.range_guard", 512'(c6_coefs), 512'(e6));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
